// File: rtl/cordic_pipe.sv
// CORDIC pipeline: a registered quadrant pre-rotation stage followed by
// STAGES micro-rotation stages. It runs in rotation mode (drive z to 0) or
// vectoring mode (drive y to 0). There is no gain compensation.
// The whole pipeline shares one enable. A stalled output freezes every
// stage, and an empty output slot lets the pipeline move.
module cordic_pipe #(
    parameter int DWIDTH = 16,
    parameter int STAGES = 14,
    parameter int TAGW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [TAGW-1:0]          in_tag,
    input  logic signed [DWIDTH-1:0] in_x,
    input  logic signed [DWIDTH-1:0] in_y,
    input  logic signed [DWIDTH-1:0] in_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_mode,
    output logic [TAGW-1:0]          out_tag,
    output logic signed [DWIDTH-1:0] out_x,
    output logic signed [DWIDTH-1:0] out_y,
    output logic signed [DWIDTH-1:0] out_z
);

    // Angle scale: 1 rad = 2^(DWIDTH-3) LSB, so pi/2 = round(pi * 2^(DWIDTH-4)).
    localparam real PI = 3.14159265358979323846;
    localparam int HALF_PI_INT = $rtoi(PI * $itor(1 << (DWIDTH - 4)) + 0.5);
    localparam logic signed [DWIDTH-1:0] HALF_PI = HALF_PI_INT[DWIDTH-1:0];

    // Index 0 is the pre-rotation register. Index STAGES drives the outputs.
    logic                     r_valid [0:STAGES];
    logic                     r_mode  [0:STAGES];
    logic [TAGW-1:0]          r_tag   [0:STAGES];
    logic signed [DWIDTH-1:0] r_x     [0:STAGES];
    logic signed [DWIDTH-1:0] r_y     [0:STAGES];
    logic signed [DWIDTH-1:0] r_z     [0:STAGES];

    logic signed [DWIDTH-1:0] w_xNext [0:STAGES-1];
    logic signed [DWIDTH-1:0] w_yNext [0:STAGES-1];
    logic signed [DWIDTH-1:0] w_zNext [0:STAGES-1];

    logic                     w_advance;
    logic signed [DWIDTH-1:0] w_preX;
    logic signed [DWIDTH-1:0] w_preY;
    logic signed [DWIDTH-1:0] w_preZ;

    // Empty slots never stall the pipe. Only a held, unconsumed result does.
    assign w_advance = !r_valid[STAGES] || out_ready;
    assign in_ready  = w_advance;

    assign out_valid = r_valid[STAGES];
    assign out_mode  = r_mode[STAGES];
    assign out_tag   = r_tag[STAGES];
    assign out_x     = r_x[STAGES];
    assign out_y     = r_y[STAGES];
    assign out_z     = r_z[STAGES];

    // Quadrant pre-rotation by +-pi/2 so the micro-rotations only cover +-pi/2.
    always_comb begin
        w_preX = in_x;
        w_preY = in_y;
        w_preZ = in_z;
        if (!in_mode) begin
            if (in_z > HALF_PI) begin
                w_preX = -in_y;
                w_preY = in_x;
                w_preZ = in_z - HALF_PI;
            end else if (in_z < -HALF_PI) begin
                w_preX = in_y;
                w_preY = -in_x;
                w_preZ = in_z + HALF_PI;
            end
        end else if (in_x[DWIDTH-1]) begin
            if (!in_y[DWIDTH-1]) begin
                w_preX = in_y;
                w_preY = -in_x;
                w_preZ = in_z + HALF_PI;
            end else begin
                w_preX = -in_y;
                w_preY = in_x;
                w_preZ = in_z - HALF_PI;
            end
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int ATAN_INT =
            $rtoi($atan(1.0 / $itor(1 << i)) * $itor(1 << (DWIDTH - 3)) + 0.5);
        localparam logic signed [DWIDTH-1:0] ATAN_I = ATAN_INT[DWIDTH-1:0];

        logic w_dPos;

        // Rotation steers z toward zero. Vectoring steers y toward zero.
        assign w_dPos = r_mode[i] ? r_y[i][DWIDTH-1] : !r_z[i][DWIDTH-1];

        assign w_xNext[i] = w_dPos ? (r_x[i] - (r_y[i] >>> i)) : (r_x[i] + (r_y[i] >>> i));
        assign w_yNext[i] = w_dPos ? (r_y[i] + (r_x[i] >>> i)) : (r_y[i] - (r_x[i] >>> i));
        assign w_zNext[i] = w_dPos ? (r_z[i] - ATAN_I) : (r_z[i] + ATAN_I);
    end

    // All stage registers shift together on advance. Reset empties the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s <= STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_mode[s]  <= 1'b0;
                r_tag[s]   <= '0;
                r_x[s]     <= '0;
                r_y[s]     <= '0;
                r_z[s]     <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            r_mode[0]  <= in_mode;
            r_tag[0]   <= in_tag;
            r_x[0]     <= w_preX;
            r_y[0]     <= w_preY;
            r_z[0]     <= w_preZ;
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s+1] <= r_valid[s];
                r_mode[s+1]  <= r_mode[s];
                r_tag[s+1]   <= r_tag[s];
                r_x[s+1]     <= w_xNext[s];
                r_y[s+1]     <= w_yNext[s];
                r_z[s+1]     <= w_zNext[s];
            end
        end
    end

endmodule

// File: tb/tb_cordic_pipe.sv
// Directed vector table plus hand-written sequences for the cordic_pipe
// pipeline: backpressure and reset with samples in flight.
module tb_cordic_pipe;

    localparam int DWIDTH = 16;
    localparam int STAGES = 14;
    localparam int TAGW   = 4;
    localparam int TOL    = STAGES + 2;
    localparam int LAT    = STAGES + 1;
    localparam real GAIN  = 1.64676;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic [TAGW-1:0]          in_tag;
    logic signed [DWIDTH-1:0] in_x;
    logic signed [DWIDTH-1:0] in_y;
    logic signed [DWIDTH-1:0] in_z;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_mode;
    logic [TAGW-1:0]          out_tag;
    logic signed [DWIDTH-1:0] out_x;
    logic signed [DWIDTH-1:0] out_y;
    logic signed [DWIDTH-1:0] out_z;

    cordic_pipe #(.DWIDTH(DWIDTH), .STAGES(STAGES), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_tag(out_tag),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string      name;
        logic       mode;
        logic [3:0] tag;
        int         x, y, z;
        int         ex, ey, ez;
    } vec_t;

    typedef struct {
        logic [3:0] tag;
        int         ex, ey;
    } sb_t;

    vec_t vecs[8];
    sb_t  sbQ[$];

    task automatic checkNear(input string name, input int act, input int exp);
        assertCount++;
        if (act - exp > TOL || exp - act > TOL) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, want %0d +-%0d", name, act, exp, TOL);
        end
    endtask

    task automatic checkEq(input string name, input int act, input int exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int roundReal(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Sends one sample into an empty pipe and counts edges until out_valid.
    task automatic applyStimulus(input vec_t v, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = v.mode;
        in_tag   = v.tag;
        in_x     = v.x[DWIDTH-1:0];
        in_y     = v.y[DWIDTH-1:0];
        in_z     = v.z[DWIDTH-1:0];
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 4 * LAT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Compares the presented result to the vector, then confirms it is not repeated.
    task automatic checkOutput(input vec_t v, input int lat);
        checkEq({v.name, " latency"}, lat, LAT);
        checkEq({v.name, " out_valid"}, out_valid, 1);
        checkNear({v.name, " x"}, out_x, v.ex);
        checkNear({v.name, " y"}, out_y, v.ey);
        checkNear({v.name, " z"}, out_z, v.ez);
        checkEq({v.name, " mode"}, out_mode, v.mode);
        checkEq({v.name, " tag"}, out_tag, v.tag);
        @(negedge clk);
        checkEq({v.name, " no duplicate"}, out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int bx[40];
        int by[40];
        int sent;
        int got;
        int stallLeft;
        bit stallDone;
        int waitCnt;
        int stale;
        sb_t e;

        vecs[0] = '{"rot basic",      1'b0, 4'h1,  10000,      0,      0,  16468,      0,      0};
        vecs[1] = '{"rot pre neg",    1'b0, 4'h2,  10000,      0, -19302, -11645, -11645,      0};
        vecs[2] = '{"vec basic",      1'b1, 4'h3,  10000,  10000,      0,  23290,      0,   6434};
        vecs[3] = '{"vec pre pi",     1'b1, 4'h4, -10000,      0,      0,  16468,      0,  25736};
        vecs[4] = '{"vec pre q3",     1'b1, 4'h5, -10000, -10000,      0,  23290,      0, -19302};
        vecs[5] = '{"rot above pi/2", 1'b0, 4'h6,  10000,      0,  12869,      0,  16468,      0};
        vecs[6] = '{"rot at pi/2",    1'b0, 4'h7,      0,  10000,  12868, -16468,      0,      0};
        vecs[7] = '{"rot below -pi/2",1'b0, 4'h8,  10000,      0, -12869,      0, -16468,      0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_tag    = '0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkEq("reset out_valid", out_valid, 0);
        checkEq("reset out_x", out_x, 0);
        checkEq("reset out_tag", out_tag, 0);
        reset = 1'b1;
        @(negedge clk);
        checkEq("post-reset in_ready", in_ready, 1);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k], lat);
            checkOutput(vecs[k], lat);
        end

        // Back-to-back stream with a 5-cycle stall once the pipe is full.
        for (int k = 0; k < 40; k++) begin
            bx[k] = int'($urandom_range(12000)) - 6000;
            by[k] = int'($urandom_range(12000)) - 6000;
        end
        sent = 0;
        got = 0;
        stallLeft = 0;
        stallDone = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
            @(negedge clk);
            if (!stallDone && got >= 5) begin
                stallLeft = 5;
                stallDone = 1'b1;
            end
            out_ready = (stallLeft == 0);
            if (sent < 40) begin
                in_valid = 1'b1;
                in_mode  = 1'b0;
                in_tag   = sent[3:0];
                in_x     = bx[sent][DWIDTH-1:0];
                in_y     = by[sent][DWIDTH-1:0];
                in_z     = '0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stallLeft > 0) begin
                checkEq("stall in_ready", in_ready, 0);
                checkEq("stall out_valid", out_valid, 1);
                if (sbQ.size() > 0) begin
                    checkEq("stall held tag", out_tag, sbQ[0].tag);
                    checkNear("stall held x", out_x, sbQ[0].ex);
                end
                stallLeft--;
            end
            if (in_valid && in_ready) begin
                e.tag = sent[3:0];
                e.ex  = roundReal(GAIN * $itor(bx[sent]));
                e.ey  = roundReal(GAIN * $itor(by[sent]));
                sbQ.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkEq("stream unexpected output", 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    checkEq("stream tag order", out_tag, e.tag);
                    checkNear("stream x", out_x, e.ex);
                    checkNear("stream y", out_y, e.ey);
                end
                got++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkEq("stream received count", got, 40);
        checkEq("stream leftover", sbQ.size(), 0);
        checkEq("stream stall seen", stallDone, 1);

        // Reset while eight samples are in flight and one is held at the output.
        repeat (LAT + 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_mode  = 1'b1;
            in_tag   = 4'(k + 1);
            in_x     = 16'sd10000;
            in_y     = '0;
            in_z     = '0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        waitCnt = 0;
        while (!out_valid && waitCnt < 4 * LAT) begin
            @(negedge clk);
            waitCnt++;
        end
        checkEq("pre-reset out_valid", out_valid, 1);
        checkEq("pre-reset in_ready", in_ready, 0);
        #2;
        reset = 1'b0;
        #1;
        checkEq("async reset out_valid", out_valid, 0);
        checkEq("async reset out_x", out_x, 0);
        checkEq("async reset out_y", out_y, 0);
        checkEq("async reset out_z", out_z, 0);
        checkEq("async reset out_mode", out_mode, 0);
        checkEq("async reset out_tag", out_tag, 0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkEq("release in_ready", in_ready, 1);
        stale = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkEq("no stale after reset", stale, 0);
        vecs[0].tag = 4'h9;
        vecs[0].name = "after reset";
        applyStimulus(vecs[0], lat);
        checkOutput(vecs[0], lat);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
